// File: rtl/ysyx_041461_mem_stage_pkg.sv
// Shared encodings for the MEM stage: memory-op codes, trap codes, FSM states.
package ysyx_041461_mem_stage_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  // MEM_ctrl operation codes
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LD  = 4'd4;
  localparam logic [3:0] MEM_LBU = 4'd5;
  localparam logic [3:0] MEM_LHU = 4'd6;
  localparam logic [3:0] MEM_LWU = 4'd7;
  localparam logic [3:0] MEM_SB  = 4'd8;
  localparam logic [3:0] MEM_SH  = 4'd9;
  localparam logic [3:0] MEM_SW  = 4'd10;
  localparam logic [3:0] MEM_SD  = 4'd11;

  // Trap codes (values follow the RISC-V exception cause numbers)
  localparam logic [3:0] TRAP_NOP                = 4'd0;
  localparam logic [3:0] TRAP_LOAD_MISALIGN      = 4'd4;
  localparam logic [3:0] TRAP_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] TRAP_STORE_MISALIGN     = 4'd6;
  localparam logic [3:0] TRAP_STORE_ACCESS_FAULT = 4'd7;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/ysyx_041461_mem_stage_align.sv
// Combinational alignment helper: misalignment check, store data/mask
// lane placement and load data extraction/extension.
module ysyx_041461_mem_align
  import ysyx_041461_mem_stage_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [2:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_load,
  output logic              is_store,
  output logic              misalign,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [7:0]        wmask,
  output logic [DATA_W-1:0] load_ext
);

  logic [1:0]        size;
  logic [DATA_W-1:0] rsh;

  // Decode op class and access size (0=B,1=H,2=W,3=D); unknown codes act as NOP
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (op)
      MEM_LB, MEM_LBU: begin is_load  = 1'b1; size = 2'd0; end
      MEM_LH, MEM_LHU: begin is_load  = 1'b1; size = 2'd1; end
      MEM_LW, MEM_LWU: begin is_load  = 1'b1; size = 2'd2; end
      MEM_LD:          begin is_load  = 1'b1; size = 2'd3; end
      MEM_SB:          begin is_store = 1'b1; size = 2'd0; end
      MEM_SH:          begin is_store = 1'b1; size = 2'd1; end
      MEM_SW:          begin is_store = 1'b1; size = 2'd2; end
      MEM_SD:          begin is_store = 1'b1; size = 2'd3; end
      default: ;
    endcase
  end

  // Natural-alignment check and store lane placement
  always_comb begin
    case (size)
      2'd1:    misalign = off[0];
      2'd2:    misalign = |off[1:0];
      2'd3:    misalign = |off;
      default: misalign = 1'b0;
    endcase
    wdata_sh = wdata << {off, 3'b000};
    case (size)
      2'd0:    wmask = 8'h01;
      2'd1:    wmask = 8'h03;
      2'd2:    wmask = 8'h0F;
      default: wmask = 8'hFF;
    endcase
    wmask = is_store ? (wmask << off) : 8'h00;
  end

  // Bring the addressed bytes down to bit 0, then sign/zero extend
  always_comb begin
    rsh = rdata >> {off, 3'b000};
    case (op)
      MEM_LB:  load_ext = {{56{rsh[7]}},  rsh[7:0]};
      MEM_LH:  load_ext = {{48{rsh[15]}}, rsh[15:0]};
      MEM_LW:  load_ext = {{32{rsh[31]}}, rsh[31:0]};
      MEM_LD:  load_ext = rsh;
      MEM_LBU: load_ext = {56'd0, rsh[7:0]};
      MEM_LHU: load_ext = {48'd0, rsh[15:0]};
      MEM_LWU: load_ext = {32'd0, rsh[31:0]};
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_041461_mem_stage.sv
// MEM stage: issues loads/stores on a valid/ready port and stalls the
// pipeline until the response returns. Non-accesses pass through with zero
// latency. Optional macro YSYX_041461_MEM_ACCESS_FAULT_EN turns rsp_err into
// an access-fault trap; otherwise rsp_err is ignored.
module ysyx_041461_mem_stage
  import ysyx_041461_mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_mem_ctrl,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [3:0]        in_trap,
  output logic              mem_stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wen,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [7:0]        req_wmask,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_load_data,
  output logic [3:0]        out_trap
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;
  logic [3:0]        trap_q, trap_d;
  logic              is_load, is_store, misalign, access;
  logic [DATA_W-1:0] load_ext;

  ysyx_041461_mem_align u_align (
    .op       (in_mem_ctrl),
    .off      (in_addr[2:0]),
    .wdata    (in_wdata),
    .rdata    (rsp_rdata),
    .is_load  (is_load),
    .is_store (is_store),
    .misalign (misalign),
    .wdata_sh (req_wdata),
    .wmask    (req_wmask),
    .load_ext (load_ext)
  );

  // Request fields come straight from the held MEM register contents
  assign req_addr = {in_addr[ADDR_W-1:3], 3'b000};
  assign req_wen  = is_store;
  assign access   = in_valid && (is_load || is_store) && (in_trap == TRAP_NOP) && !misalign;

`ifndef YSYX_041461_MEM_ACCESS_FAULT_EN
  logic unused_rsp_err;
  assign unused_rsp_err = rsp_err;
`endif

  // Access FSM, stall/handshake outputs and result selection
  always_comb begin
    state_d       = state_q;
    ldata_d       = ldata_q;
    trap_d        = trap_q;
    mem_stall     = 1'b0;
    req_valid     = 1'b0;
    out_valid     = 1'b0;
    out_load_data = '0;
    out_trap      = TRAP_NOP;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          mem_stall = 1'b1;
          state_d   = ST_REQ;
        end else begin
          out_valid = in_valid;
          if (in_trap != TRAP_NOP)
            out_trap = in_trap;
          else if (in_valid && misalign)
            out_trap = is_store ? TRAP_STORE_MISALIGN : TRAP_LOAD_MISALIGN;
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        req_valid = 1'b1;
        if (req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        mem_stall = 1'b1;
        if (rsp_valid) begin
          ldata_d = load_ext;
          trap_d  = TRAP_NOP;
`ifdef YSYX_041461_MEM_ACCESS_FAULT_EN
          if (rsp_err) begin
            ldata_d = '0;
            trap_d  = is_store ? TRAP_STORE_ACCESS_FAULT : TRAP_LOAD_ACCESS_FAULT;
          end
`endif
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid     = 1'b1;
        out_load_data = ldata_q;
        out_trap      = trap_q;
        state_d       = ST_IDLE;
      end
    endcase
    // Reset masks everything seen by the WB register and the memory
    if (rst) begin
      mem_stall = 1'b0;
      req_valid = 1'b0;
      out_valid = 1'b0;
      out_trap  = TRAP_NOP;
    end
  end

  // State and captured-result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ldata_q <= '0;
      trap_q  <= TRAP_NOP;
    end else begin
      state_q <= state_d;
      ldata_q <= ldata_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_mem_stage.sv
// Directed bench for the MEM stage: a small memory responder in the access
// task, expected results queued at drive time and popped on out_valid.
module tb_ysyx_041461_mem_stage;
  import ysyx_041461_mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_mem_ctrl;
  logic [63:0] in_addr, in_wdata;
  logic [3:0]  in_trap;
  logic        mem_stall, req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        out_valid;
  logic [63:0] out_load_data;
  logic [3:0]  out_trap;

  typedef struct { logic [63:0] data; logic [3:0] trap; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_041461_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_ctrl(in_mem_ctrl),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_trap(in_trap),
    .mem_stall(mem_stall), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .out_valid(out_valid), .out_load_data(out_load_data),
    .out_trap(out_trap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_mem_ctrl = MEM_NOP; in_addr = '0; in_wdata = '0;
    in_trap = TRAP_NOP; req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    rsp_rdata = '0;
  endtask

  // One full memory access; the responder answers one cycle after acceptance
  task automatic access(input string tag, input logic [3:0] op, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input int wait_n, input logic err,
                        input logic [63:0] exp_data, input logic [3:0] exp_trap,
                        input int exp_stall, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata);
    int stalls = 0;
    int w = wait_n;
    bit seen_req = 0, pend = 0, done = 0;
    exp_t e;
    sb.push_back('{exp_data, exp_trap});
    @(negedge clk);
    in_valid = 1'b1; in_mem_ctrl = op; in_addr = addr; in_wdata = wdata; in_trap = TRAP_NOP;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      rsp_valid = 1'b0; rsp_err = 1'b0; req_ready = 1'b0;
      if (mem_stall) stalls++;
      if (out_valid) begin
        e = sb.pop_front();
        chk({tag, " load_data"}, out_load_data, e.data);
        chk({tag, " trap"}, {60'd0, out_trap}, {60'd0, e.trap});
        done = 1;
      end else if (req_valid) begin
        chk({tag, " req_addr"}, req_addr, {addr[63:3], 3'b000});
        if (!seen_req) begin
          chk({tag, " req_wen"}, {63'd0, req_wen}, {63'd0, exp_mask != 8'h00});
          chk({tag, " req_wmask"}, {56'd0, req_wmask}, {56'd0, exp_mask});
          if (exp_mask != 8'h00) chk({tag, " req_wdata"}, req_wdata, exp_wdata);
          seen_req = 1;
        end
        if (w > 0) w--;
        else begin req_ready = 1'b1; pend = 1; end
      end else if (pend) begin
        rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err; pend = 0;
      end
      if (!done) @(negedge clk);
    end
    chk({tag, " completed"}, {63'd0, done}, 64'd1);
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(exp_stall));
    idle_inputs();
  endtask

  // Non-access: result must appear in the same cycle with no request
  task automatic passthru(input string tag, input logic [3:0] op, input logic [63:0] addr,
                          input logic [3:0] trap_in, input logic [3:0] exp_trap);
    @(negedge clk);
    in_valid = 1'b1; in_mem_ctrl = op; in_addr = addr; in_trap = trap_in;
    #1;
    chk({tag, " stall"}, {63'd0, mem_stall}, 64'd0);
    chk({tag, " req_valid"}, {63'd0, req_valid}, 64'd0);
    chk({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, " trap"}, {60'd0, out_trap}, {60'd0, exp_trap});
    @(negedge clk); #1;
    chk({tag, " no_req_next"}, {63'd0, req_valid}, 64'd0);
    idle_inputs();
  endtask

  initial begin
    logic [3:0] fault_trap;
    logic [63:0] fault_data;
    idle_inputs();
    rst = 1'b1;
    // Reset masking: an aligned load with a pending trap must not leak out
    in_valid = 1'b1; in_mem_ctrl = MEM_LD; in_addr = 64'h8000_0000; in_trap = TRAP_LOAD_MISALIGN;
    @(negedge clk); #1;
    chk("rst stall", {63'd0, mem_stall}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_trap", {60'd0, out_trap}, 64'd0);
    chk("rst req_valid", {63'd0, req_valid}, 64'd0);
    idle_inputs();
    @(negedge clk); rst = 1'b0;

    access("LB", MEM_LB, 64'h8000_0003, '0, 64'h0000_0000_8000_0000, 0, 1'b0,
           64'hFFFF_FFFF_FFFF_FF80, TRAP_NOP, 3, 8'h00, '0);
    access("SH", MEM_SH, 64'h8000_0006, 64'h1234, '0, 0, 1'b0,
           64'd0, TRAP_NOP, 3, 8'hC0, 64'h1234_0000_0000_0000);
    access("LD_wait", MEM_LD, 64'h8000_0008, '0, 64'h0123_4567_89AB_CDEF, 4, 1'b0,
           64'h0123_4567_89AB_CDEF, TRAP_NOP, 7, 8'h00, '0);
    access("LH", MEM_LH, 64'h8000_0002, '0, 64'h0000_0000_9ABC_0000, 1, 1'b0,
           64'hFFFF_FFFF_FFFF_9ABC, TRAP_NOP, 4, 8'h00, '0);
    access("LHU", MEM_LHU, 64'h8000_0002, '0, 64'h0000_0000_9ABC_0000, 0, 1'b0,
           64'h0000_0000_0000_9ABC, TRAP_NOP, 3, 8'h00, '0);
    access("LW", MEM_LW, 64'h8000_0004, '0, 64'h8765_4321_0000_0000, 0, 1'b0,
           64'hFFFF_FFFF_8765_4321, TRAP_NOP, 3, 8'h00, '0);
    access("SB", MEM_SB, 64'h8000_0005, 64'hAB, '0, 0, 1'b0,
           64'd0, TRAP_NOP, 3, 8'h20, 64'h0000_AB00_0000_0000);
    access("SW", MEM_SW, 64'h8000_0004, 64'hDEAD_BEEF, '0, 0, 1'b0,
           64'd0, TRAP_NOP, 3, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    access("SD", MEM_SD, 64'h8000_0010, 64'h1122_3344_5566_7788, '0, 0, 1'b0,
           64'd0, TRAP_NOP, 3, 8'hFF, 64'h1122_3344_5566_7788);

`ifdef YSYX_041461_MEM_ACCESS_FAULT_EN
    fault_trap = TRAP_LOAD_ACCESS_FAULT; fault_data = 64'd0;
`else
    fault_trap = TRAP_NOP; fault_data = 64'h0000_0000_DEAD_BEEF;
`endif
    access("LWU_err", MEM_LWU, 64'h8000_0004, '0, 64'hDEAD_BEEF_1234_5678, 0, 1'b1,
           fault_data, fault_trap, 3, 8'h00, '0);

    passthru("LW_mis", MEM_LW, 64'h8000_0002, TRAP_NOP, TRAP_LOAD_MISALIGN);
    passthru("SD_mis", MEM_SD, 64'h8000_0004, TRAP_NOP, TRAP_STORE_MISALIGN);
    passthru("SD_trap", MEM_SD, 64'h8000_0000, TRAP_LOAD_ACCESS_FAULT, TRAP_LOAD_ACCESS_FAULT);
    passthru("NOP", MEM_NOP, 64'h8000_0001, TRAP_NOP, TRAP_NOP);

    // Stray response in IDLE must not produce a result
    @(negedge clk); rsp_valid = 1'b1; rsp_rdata = 64'hFF;
    @(negedge clk); rsp_valid = 1'b0; #1;
    chk("stray_rsp out_valid", {63'd0, out_valid}, 64'd0);

    // Reset while waiting in RESP abandons the access
    @(negedge clk);
    in_valid = 1'b1; in_mem_ctrl = MEM_LD; in_addr = 64'h8000_0020;
    @(negedge clk); #1;
    chk("rstmid req_valid", {63'd0, req_valid}, 64'd1);
    req_ready = 1'b1;
    @(negedge clk); req_ready = 1'b0; #1;
    chk("rstmid resp_stall", {63'd0, mem_stall}, 64'd1);
    chk("rstmid resp_noreq", {63'd0, req_valid}, 64'd0);
    rst = 1'b1; #1;
    chk("rstmid stall_in_rst", {63'd0, mem_stall}, 64'd0);
    chk("rstmid out_valid_in_rst", {63'd0, out_valid}, 64'd0);
    @(negedge clk); rst = 1'b0; idle_inputs(); #1;
    chk("rstmid after req_valid", {63'd0, req_valid}, 64'd0);
    chk("rstmid after out_valid", {63'd0, out_valid}, 64'd0);
    chk("rstmid after stall", {63'd0, mem_stall}, 64'd0);
    // A fresh access afterwards still works from IDLE
    access("LBU_after_rst", MEM_LBU, 64'h8000_0001, '0, 64'h0000_0000_0000_F000, 0, 1'b0,
           64'h0000_0000_0000_00F0, TRAP_NOP, 3, 8'h00, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
